// File: rtl/aes_cipher_iterative.sv
// AES-128 iterative encryptor: one round per clock, out_valid exactly 10 cycles after the accept edge.
// One block in flight: in_ready is low while busy, and the ciphertext is held in DONE until out_ready.
module aes_cipher_iterative #(
  parameter int NR = 10,
  parameter int NS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [32*NS-1:0]        plaintext,
  input  logic [32*NS*(NR+1)-1:0] key_w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [32*NS-1:0]        ciphertext,
  output logic                    busy
);
  localparam int BW = 32 * NS;
  localparam int KW = BW * (NR + 1);

  // Byte 0 of every 128-bit word is its most significant byte (bits [127:120]).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [3:0]        rnd_q, rnd_d;
  logic [BW-1:0]     state_q, state_d;
  logic [KW-1:0]     key_q, key_d;
  logic [BW-1:0]     ct_q, ct_d;
  logic [BW-1:0]     rk, round_out;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [31:0]  col;
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    // Row r of column c takes the byte from column c+r.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
      if (last) col = {a0, a1, a2, a3};
      else col = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      o[127-32*c -: 32] = col ^ k[127-32*c -: 32];
    end
    return o;
  endfunction

  assign rk        = key_q[(KW-1) - BW*int'(rnd_q) -: BW];
  assign round_out = aes_round(state_q, rk, rnd_q == 4'(NR));

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    key_d   = key_q;
    ct_d    = ct_q;
    case (fsm_q)
      IDLE: begin
        // Inputs are only sampled on acceptance, so junk on them never reaches the state.
        if (in_valid) begin
          key_d   = key_w;
          state_d = plaintext ^ key_w[KW-1 -: BW];
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_out;
        rnd_d   = rnd_q + 4'd1;
        if (rnd_q == 4'(NR)) begin
          ct_d  = round_out;
          rnd_d = '0;
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      rnd_q   <= '0;
      state_q <= '0;
      key_q   <= '0;
      ct_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
    end
  end

  assign in_ready   = (fsm_q == IDLE);
  assign out_valid  = (fsm_q == DONE);
  assign busy       = (fsm_q != IDLE);
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_cipher_iterative.sv
// Directed and random checks of the iterative AES-128 encryptor against FIPS-197 vectors
// and an independent reference model whose S-box is derived from GF(2^8) inversion.
module tb_aes_cipher_iterative;
  logic           clk = 1'b0;
  logic           rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0]   plaintext, ciphertext;
  logic [1407:0]  key_w;
  int             n_chk = 0;
  int             n_pass = 0;
  int             cyc = 0;
  logic [7:0]     sb_t [256];

  typedef struct { logic [127:0] key; logic [127:0] pt; logic [127:0] ct; } vec_t;
  vec_t vec [3];

  aes_cipher_iterative dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key_w(key_w), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] kw;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) kw[1407-32*i -: 32] = w[i];
    return kw;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [1407:0] kw;
    logic [7:0]    s [16];
    logic [7:0]    t [16];
    logic [7:0]    a [4];
    logic [127:0]  o;
    kw = expand(key);
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ kw[1407-8*k -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int k = 0; k < 16; k++) t[k] = sb_t[s[k]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (rd < 10)
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) a[row] = s[4*c+row];
          s[4*c]   = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
          s[4*c+1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
          s[4*c+2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
          s[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
        end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ kw[1407-128*rd-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  task automatic scramble();
    plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 0; i < 44; i++) key_w[32*i +: 32] = $urandom();
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Accept one block, scramble inputs right after acceptance, check latency, result and drain.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp_ct, input string tag);
    int n;
    chk({tag, " ready"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1; plaintext = pt; key_w = expand(key);
    tick();
    in_valid = 1'b0;
    scramble();
    wait_out(n);
    chk({tag, " latency"}, 128'(n), 128'd10);
    chk({tag, " ct"}, ciphertext, exp_ct);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " drained"}, 128'({in_ready, out_valid}), 128'b10);
    chk({tag, " ct kept"}, ciphertext, exp_ct);
  endtask

  initial begin
    int n, acc, prev_acc;
    logic [127:0] k, p, e;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    vec[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vec[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
               128'h3925841d02dc09fbdc118597196a0b32};
    vec[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key_w = '0;
    repeat (2) tick();
    chk("reset in_ready", 128'(in_ready), 128'd1);
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset busy", 128'(busy), 128'd0);
    chk("reset ct", ciphertext, 128'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) run_block(vec[i].pt, vec[i].key, vec[i].ct, $sformatf("vec%0d", i));

    // Internal state after round 1 of the App.B example.
    in_valid = 1'b1; plaintext = vec[1].pt; key_w = expand(vec[1].key);
    tick();
    in_valid = 1'b0;
    tick();
    chk("appB round1 state", dut.state_q, 128'ha49c7ff2689f352b6b5bea43026a5049);
    wait_out(n);
    chk("appB ct", ciphertext, vec[1].ct);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Backpressure: hold DONE for 20 cycles with a competing in_valid that must be ignored.
    in_valid = 1'b1; plaintext = vec[0].pt; key_w = expand(vec[0].key);
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk("bp latency", 128'(n), 128'd10);
    for (int i = 0; i < 20; i++) begin
      if (i >= 5) begin
        in_valid = 1'b1;
        scramble();
      end
      tick();
      chk("bp ct stable", ciphertext, vec[0].ct);
      chk("bp hold", 128'({out_valid, in_ready, busy}), 128'b101);
    end
    plaintext = vec[1].pt; key_w = expand(vec[1].key); out_ready = 1'b1;
    tick();
    chk("bp handshake only", 128'({out_valid, in_ready, busy}), 128'b010);
    chk("bp ct after drain", ciphertext, vec[0].ct);
    tick();
    in_valid = 1'b0;
    chk("bp accepted next", 128'(busy), 128'd1);
    wait_out(n);
    chk("bp2 latency", 128'(n), 128'd10);
    chk("bp2 ct", ciphertext, vec[1].ct);
    tick();
    out_ready = 1'b0;
    chk("bp2 drained", 128'(in_ready), 128'd1);

    // Reset at round 5 of the App.B block.
    in_valid = 1'b1; plaintext = vec[1].pt; key_w = expand(vec[1].key);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst flags", 128'({in_ready, out_valid, busy}), 128'b100);
    chk("midrst ct", ciphertext, 128'd0);
    chk("midrst state", dut.state_q, 128'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (out_valid !== 1'b0) n++;
    end
    chk("midrst no pulse", 128'(n), 128'd0);
    run_block(vec[1].pt, vec[1].key, vec[1].ct, "after rst");

    // Back-to-back random blocks with out_ready tied high.
    out_ready = 1'b1;
    prev_acc = 0;
    for (int b = 0; b < 100; b++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      e = aes_ref(p, k);
      in_valid = 1'b1; plaintext = p; key_w = expand(k);
      tick();
      acc = cyc;
      in_valid = 1'b0;
      scramble();
      if (b > 0) chk($sformatf("b2b%0d interval", b), 128'(acc - prev_acc), 128'd12);
      prev_acc = acc;
      wait_out(n);
      chk($sformatf("b2b%0d ct", b), ciphertext, e);
      tick();
    end
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
